// File: rtl/uart_tx_engine.sv
// UART transmitter with an integrated TX FIFO.
// Data width, parity mode, stop-bit count and baud divisor are sampled when a
// word is popped from the FIFO, so changing the format never disturbs a frame
// already on the line.
module uart_tx_engine #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 24,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DIV_W-1:0] cfg_divisor_i,
    input  logic [1:0]       cfg_data_bits_i,
    input  logic [2:0]       cfg_parity_i,
    input  logic             cfg_stop2_i,
    input  logic             wr_en_i,
    input  logic [7:0]       din_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output logic             busy_o,
    output logic             overflow_o,
    output logic             tx_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } state_t;

    // Clear the bits above the configured data width (0=5 .. 3=8 bits).
    function automatic logic [7:0] mask_data(input logic [7:0] d, input logic [1:0] bits);
        logic [7:0] m;
        case (bits)
            2'd0:    m = 8'h1F;
            2'd1:    m = 8'h3F;
            2'd2:    m = 8'h7F;
            default: m = 8'hFF;
        endcase
        return d & m;
    endfunction

    // Only the four defined parity codes add a parity bit; the rest mean none.
    function automatic logic parity_enabled(input logic [2:0] mode);
        logic en;
        case (mode)
            3'b001, 3'b010, 3'b100, 3'b101: en = 1'b1;
            default:                        en = 1'b0;
        endcase
        return en;
    endfunction

    // Parity bit over already-masked data (upper bits are zero).
    function automatic logic parity_value(input logic [7:0] d, input logic [2:0] mode);
        logic p;
        case (mode)
            3'b001:  p = ~^d;
            3'b010:  p = ^d;
            3'b101:  p = 1'b1;
            default: p = 1'b0;
        endcase
        return p;
    endfunction

    logic [1:0]       rst_sync_q;
    logic             rst_n_s;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
    logic             push_s, pop_s;
    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, div_eff_s;
    logic [7:0]       shift_q, shift_d, head_s;
    logic [2:0]       bit_idx_q, bit_idx_d, last_idx_s;
    logic [1:0]       nbits_q, nbits_d;
    logic             par_en_q, par_en_d, par_bit_q, par_bit_d, stop2_q, stop2_d;
    logic             tx_q, tx_d, busy_q, busy_d;

    // Reset asserts asynchronously and is released through two flops.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_s    = rst_sync_q[1];
    assign div_eff_s  = (cfg_divisor_i == {DIV_W{1'b0}}) ? DIV_W'(1) : cfg_divisor_i;
    assign head_s     = mask_data(mem_q[rptr_q], cfg_data_bits_i);
    assign last_idx_s = {1'b0, nbits_q} + 3'd4;

    // FIFO bookkeeping: accept on not-full, drop and flag on full.
    always_comb begin
        push_s  = wr_en_i & ~full_q;
        ovf_d   = wr_en_i & full_q;
        wptr_d  = push_s ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d  = pop_s ? rptr_q + PTR_W'(1) : rptr_q;
        count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
        full_d  = (count_d == CNT_W'(FIFO_DEPTH));
        empty_d = (count_d == {CNT_W{1'b0}});
    end

    // Frame sequencer: next state, bit timer, shift register and next line level.
    always_comb begin
        pop_s     = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        div_d     = div_q;
        nbits_d   = nbits_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!empty_q) begin
                    pop_s     = 1'b1;
                    state_d   = ST_START;
                    tx_d      = 1'b0;
                    div_d     = div_eff_s;
                    cnt_d     = div_eff_s - DIV_W'(1);
                    nbits_d   = cfg_data_bits_i;
                    shift_d   = head_s;
                    bit_idx_d = 3'd0;
                    par_en_d  = parity_enabled(cfg_parity_i);
                    par_bit_d = parity_value(head_s, cfg_parity_i);
                    stop2_d   = cfg_stop2_i;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_START: begin
                if (cnt_q == {DIV_W{1'b0}}) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                    cnt_d   = div_q - DIV_W'(1);
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == {DIV_W{1'b0}}) begin
                    cnt_d = div_q - DIV_W'(1);
                    if (bit_idx_q == last_idx_s) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP1;
                        tx_d    = par_en_q ? par_bit_q : 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            ST_PARITY: begin
                if (cnt_q == {DIV_W{1'b0}}) begin
                    state_d = ST_STOP1;
                    tx_d    = 1'b1;
                    cnt_d   = div_q - DIV_W'(1);
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            ST_STOP1: begin
                if (cnt_q == {DIV_W{1'b0}}) begin
                    state_d = stop2_q ? ST_STOP2 : ST_IDLE;
                    tx_d    = 1'b1;
                    cnt_d   = stop2_q ? div_q - DIV_W'(1) : {DIV_W{1'b0}};
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            ST_STOP2: begin
                if (cnt_q == {DIV_W{1'b0}}) begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk_i or negedge rst_n_s) begin
        if (!rst_n_s) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (push_s) begin
            mem_q[wptr_q] <= din_i;
        end
    end

    // State, frame and flag registers.
    always_ff @(posedge clk_i or negedge rst_n_s) begin
        if (!rst_n_s) begin
            wptr_q    <= {PTR_W{1'b0}};
            rptr_q    <= {PTR_W{1'b0}};
            count_q   <= {CNT_W{1'b0}};
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
            state_q   <= ST_IDLE;
            cnt_q     <= {DIV_W{1'b0}};
            div_q     <= DIV_W'(1);
            shift_q   <= 8'h00;
            bit_idx_q <= 3'd0;
            nbits_q   <= 2'd3;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            nbits_q   <= nbits_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign count_o    = count_q;
    assign busy_o     = busy_q;
    assign overflow_o = ovf_q;
    assign tx_o       = tx_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: table of single frames with hand-computed
// line patterns, plus back-to-back, FIFO overflow and reset sequences.
module tb_uart_tx_engine;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [23:0] cfg_divisor_i = 24'd1;
    logic [1:0]  cfg_data_bits_i = 2'd3;
    logic [2:0]  cfg_parity_i = 3'b000;
    logic        cfg_stop2_i = 1'b0;
    logic        wr_en_i = 1'b0;
    logic [7:0]  din_i = 8'h00;
    logic        full_o, empty_o, busy_o, overflow_o, tx_o;
    logic [4:0]  count_o;

    int checks = 0;
    int errors = 0;

    uart_tx_engine dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cfg_divisor_i  (cfg_divisor_i),
        .cfg_data_bits_i(cfg_data_bits_i),
        .cfg_parity_i   (cfg_parity_i),
        .cfg_stop2_i    (cfg_stop2_i),
        .wr_en_i        (wr_en_i),
        .din_i          (din_i),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .count_o        (count_o),
        .busy_o         (busy_o),
        .overflow_o     (overflow_o),
        .tx_o           (tx_o)
    );

    always #5 clk_i = ~clk_i;

    // exp_bits[i] is the i-th bit on the line, starting with the start bit.
    typedef struct {
        logic [23:0] div;
        logic [1:0]  dbits;
        logic [2:0]  par;
        logic        stop2;
        logic [7:0]  din;
        logic [11:0] exp_bits;
        int          nb;
        int          d;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Called at the negedge of the first start-bit cycle; ends at the gap cycle.
    task automatic check_frame(input logic [11:0] bits, input int nb, input int d,
                               input logic scramble, input string tag);
        for (int i = 0; i < nb; i++) begin
            for (int c = 0; c < d; c++) begin
                if (scramble && i == 1 && c == 0) begin
                    cfg_divisor_i   = 24'd7;
                    cfg_data_bits_i = 2'd0;
                    cfg_parity_i    = 3'b101;
                    cfg_stop2_i     = ~cfg_stop2_i;
                end
                chk($sformatf("%s tx bit%0d cyc%0d", tag, i, c), 32'(tx_o), 32'(bits[i]));
                chk($sformatf("%s busy bit%0d cyc%0d", tag, i, c), 32'(busy_o), 32'd1);
                @(negedge clk_i);
            end
        end
        chk({tag, " gap tx"}, 32'(tx_o), 32'd1);
        chk({tag, " gap busy"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        int pulses;
        int bad;

        //          div     bits  par     stop2 din    line bits nb  d
        vecs[0] = '{24'd4, 2'd3, 3'b001, 1'b0, 8'h55, 12'h6AA, 11, 4};
        vecs[1] = '{24'd3, 2'd0, 3'b010, 1'b1, 8'hFF, 12'h1FE,  9, 3};
        vecs[2] = '{24'd2, 2'd1, 3'b100, 1'b0, 8'hC5, 12'h10A,  9, 2};
        vecs[3] = '{24'd1, 2'd2, 3'b101, 1'b1, 8'h80, 12'h700, 11, 1};
        vecs[4] = '{24'd2, 2'd3, 3'b001, 1'b0, 8'h01, 12'h402, 11, 2};
        vecs[5] = '{24'd1, 2'd0, 3'b011, 1'b0, 8'hFF, 12'h07E,  7, 1};

        // Power-on reset, then idle for 50 cycles.
        #1 rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("in-reset tx", 32'(tx_o), 32'd1);
        chk("in-reset busy", 32'(busy_o), 32'd0);
        rst_i = 1'b1;
        repeat (50) @(negedge clk_i);
        chk("reset tx", 32'(tx_o), 32'd1);
        chk("reset empty", 32'(empty_o), 32'd1);
        chk("reset full", 32'(full_o), 32'd0);
        chk("reset count", 32'(count_o), 32'd0);
        chk("reset busy", 32'(busy_o), 32'd0);
        chk("reset overflow", 32'(overflow_o), 32'd0);

        // Single frames from the table; config is scrambled mid-frame.
        for (int v = 0; v < 6; v++) begin
            @(negedge clk_i);
            cfg_divisor_i   = vecs[v].div;
            cfg_data_bits_i = vecs[v].dbits;
            cfg_parity_i    = vecs[v].par;
            cfg_stop2_i     = vecs[v].stop2;
            din_i           = vecs[v].din;
            wr_en_i         = 1'b1;
            @(negedge clk_i);
            wr_en_i = 1'b0;
            chk($sformatf("vec%0d pre-start tx", v), 32'(tx_o), 32'd1);
            chk($sformatf("vec%0d count after push", v), 32'(count_o), 32'd1);
            chk($sformatf("vec%0d empty after push", v), 32'(empty_o), 32'd0);
            @(negedge clk_i);
            check_frame(vecs[v].exp_bits, vecs[v].nb, vecs[v].d, 1'b1, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d empty after frame", v), 32'(empty_o), 32'd1);
        end

        // Back-to-back frames with divisor 0 (treated as 1).
        @(negedge clk_i);
        cfg_divisor_i   = 24'd0;
        cfg_data_bits_i = 2'd3;
        cfg_parity_i    = 3'b000;
        cfg_stop2_i     = 1'b0;
        din_i           = 8'hA3;
        wr_en_i         = 1'b1;
        @(negedge clk_i);
        din_i = 8'h0F;
        @(negedge clk_i);
        wr_en_i = 1'b0;
        check_frame(12'h346, 10, 1, 1'b0, "b2b A3");
        chk("b2b queued count", 32'(count_o), 32'd1);
        @(negedge clk_i);
        check_frame(12'h21E, 10, 1, 1'b0, "b2b 0F");
        chk("b2b drained empty", 32'(empty_o), 32'd1);
        chk("b2b drained count", 32'(count_o), 32'd0);

        // Fill the FIFO behind a slow frame, then hammer it while full.
        cfg_divisor_i = 24'd100;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk_i);
            din_i   = 8'(k);
            wr_en_i = 1'b1;
        end
        @(negedge clk_i);
        wr_en_i = 1'b0;
        chk("fill count", 32'(count_o), 32'd16);
        chk("fill full", 32'(full_o), 32'd1);
        chk("fill no overflow", 32'(overflow_o), 32'd0);
        chk("fill busy", 32'(busy_o), 32'd1);
        pulses = 0;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk_i);
            wr_en_i = 1'b1;
            @(negedge clk_i);
            wr_en_i = 1'b0;
            if (overflow_o === 1'b1) pulses++;
            chk($sformatf("overflow count %0d", k), 32'(count_o), 32'd16);
            @(negedge clk_i);
            chk($sformatf("overflow pulse end %0d", k), 32'(overflow_o), 32'd0);
        end
        chk("overflow pulses", 32'(pulses), 32'd17);
        chk("still full", 32'(full_o), 32'd1);

        // Reset clears the full FIFO and the frame in flight.
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("flush count", 32'(count_o), 32'd0);
        chk("flush full", 32'(full_o), 32'd0);
        chk("flush tx", 32'(tx_o), 32'd1);
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (4) @(negedge clk_i);

        // Reset in the middle of the data bits of a D=8 frame with 3 queued.
        cfg_divisor_i = 24'd8;
        din_i         = 8'h00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            wr_en_i = 1'b1;
        end
        @(negedge clk_i);
        wr_en_i = 1'b0;
        chk("midreset queued", 32'(count_o), 32'd3);
        repeat (10) @(negedge clk_i);
        chk("midreset in data tx", 32'(tx_o), 32'd0);
        chk("midreset in data busy", 32'(busy_o), 32'd1);
        #2 rst_i = 1'b0;
        #1;
        chk("midreset tx", 32'(tx_o), 32'd1);
        chk("midreset count", 32'(count_o), 32'd0);
        chk("midreset empty", 32'(empty_o), 32'd1);
        chk("midreset busy", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk_i);
            if (tx_o !== 1'b1 || busy_o !== 1'b0) bad++;
        end
        chk("no frame after reset", 32'(bad), 32'd0);
        chk("empty after reset", 32'(empty_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
Synthesizable, parametrised UART transmitter with an integrated TX FIFO. It supersedes the fixed-format transmit path of the UART peripheral with runtime-configurable data width (5–8), parity mode, stop-bit count and baud divisor. It sits between the UART register interface (the producer of wr_en_i/din_i) and the board tx pin. Configuration is sampled per frame, so format changes never corrupt a frame in flight.

Parameters:
FIFO_DEPTH, 16, TX FIFO entries; power of two, at least 2.
DIV_W, 24, width of the baud divisor (bit time in clk_i cycles).
CNT_W, $clog2(FIFO_DEPTH)+1, width of count_o.

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous reset, active-low
cfg_divisor_i  in  DIV_W  clk_i cycles per bit; 0 is treated as 1
cfg_data_bits_i  in  2  data width: 0=5, 1=6, 2=7, 3=8 bits
cfg_parity_i  in  3  000 none, 001 odd, 010 even, 100 zero, 101 one; other codes = none
cfg_stop2_i  in  1  0 = 1 stop bit, 1 = 2 stop bits
wr_en_i  in  1  push din_i into the FIFO
din_i  in  8  byte to send; bits above the configured width are ignored
full_o  out  1  FIFO full
empty_o  out  1  FIFO empty
count_o  out  CNT_W  FIFO occupancy
busy_o  out  1  frame in progress (state != IDLE)
overflow_o  out  1  one-cycle pulse: write dropped because FIFO was full
tx_o  out  1  serial line, idle high

Behaviour:
- Reset (rst_i=0, asynchronous): tx_o=1, state=IDLE, FIFO emptied, empty_o=1, full_o=0, count_o=0, busy_o=0, overflow_o=0. Deassertion is synchronised internally with a 2-flop release. Reset mid-frame aborts the frame: tx_o returns high immediately, and the partially sent byte is lost.
- FIFO:
  - Write accepted when wr_en_i=1 and full_o=0.
  - If wr_en_i=1 while full_o=1, data is dropped and overflow_o pulses for 1 cycle. This holds even if a pop occurs in the same cycle, because full_o is the registered flag.
  - Simultaneous push and pop with 0 < count_o < FIFO_DEPTH leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Flags and count are registered and update the cycle after the event.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE: if empty_o=0, pop the head word and latch the divisor (0→1), data bits, parity and stop configuration into frame registers; go to START. tx_o falls on the cycle after the pop.
  - Each state drives tx_o for exactly D clk_i cycles (D = latched divisor). A DIV_W-bit down-counter is reloaded with D−1 on every state entry; the state advances when the counter reaches 0.
  - START: tx_o=0 → DATA.
  - DATA: shift LSB first, N bits (N = 5..8). After N bits → PARITY if parity enabled, else STOP1.
  - PARITY: tx_o = bit per mode. Odd = ~^data[N-1:0]; even = ^data[N-1:0]; zero = 0; one = 1. → STOP1.
  - STOP1: tx_o=1 → STOP2 if stop2, else IDLE.
  - STOP2: tx_o=1 → IDLE.
- Back-to-back frames: from the last stop-bit cycle, IDLE pops the next word in the following cycle. The inter-frame gap is exactly 1 clk_i cycle of idle high beyond the stop bit(s).
- Frame length in cycles = D × (1 + N + P + S), where P ∈ {0,1} and S ∈ {1,2}.
- busy_o=1 from the first START cycle through the last stop cycle.
- tx_o is driven from a flop; there is no combinational path from any input to tx_o.
- Config changes mid-frame have no effect until the next frame.

Test Plan:
- Reset, then hold 50 cycles → tx_o=1, empty_o=1, count_o=0, busy_o=0.
- D=4, 8 bits, odd parity, 1 stop; write 0x55 → 44-cycle frame. Line reads 0,1,0,1,0,1,0,1,0, then parity 1, then stop 1, each bit 4 cycles; busy_o drops afterwards.
- D=3, 5 bits, even parity, 2 stop; write 0xFF → data 11111, parity 1, two stop bits; frame is 27 cycles. Upper din bits are not transmitted.
- D=0, 8 bits, no parity; write 0xA3 then 0x0F back-to-back → bit time is 1 cycle. Frames are 10 cycles each with a 1-cycle gap; LSB-first data bits are 1,1,0,0,0,1,0,1 for 0xA3.
- D=100; write 17 bytes in 17 consecutive cycles with no frame active at start. The first byte is popped, so count_o peaks at 16, full_o=1, and one overflow_o pulse occurs on the 18th write attempt. Then write 16 more while full → 16 overflow pulses and count_o stays 16.
- Assert rst_i=0 mid-DATA of a D=8 frame with 3 bytes queued → tx_o=1 within the reset cycle, count_o=0. After release, no further frames are sent.
